pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Owns the write-enable and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Handles three hazard classes:
  - load-use data hazards, with a configurable multi-cycle stall;
  - taken-branch flushes resolved in EX;
  - data-memory wait states.
- Also keeps saturating stall/flush performance counters and a memory-timeout watchdog.

Parameters:
- LOAD_LAT, 1, bubbles inserted per load-use hazard (1..3; 2 when MEM->EX forwarding is absent).
- MEM_TIMEOUT, 64, consecutive dmem_busy cycles before mem_timeout is raised (>=2).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, all state on the rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  source register 1 of the instruction in ID
- id_rt  in  5  source register 2 of the instruction in ID
- id_uses_rs  in  1  ID instruction reads id_rs
- id_uses_rt  in  1  ID instruction reads id_rt
- ex_mem_read  in  1  instruction in EX is a load (ID/EX mem_read output)
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- dmem_busy  in  1  MEM-stage access not complete this cycle
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_we  out  1  ID/EX write enable
- id_ex_bubble  out  1  ID/EX loads all-zero control fields
- ex_mem_we  out  1  EX/MEM write enable
- mem_wb_bubble  out  1  MEM/WB loads zero reg_write/mem_to_reg
- stall_cycles  out  CNT_W  saturating count of load-use stall cycles
- flush_events  out  CNT_W  saturating count of taken-branch flushes
- mem_timeout  out  1  sticky watchdog error

Behaviour:
- Clock and reset: asynchronous, active-high reset on reset; all state on the rising edge of clk.
- State: state in {RUN, STALL}, bubble counter bcnt (2 bits), watchdog counter wcnt, the two perf counters, and mem_timeout.
- Reset values: state=RUN, bcnt=0, wcnt=0, counters=0, mem_timeout=0.
- Outputs during reset: pc_we=if_id_we=id_ex_we=ex_mem_we=0; if_id_flush=id_ex_bubble=mem_wb_bubble=1.
- Output timing: outputs are combinational from the current state and inputs (Mealy), taking effect on the same edge.
- Defaults (nothing active): all *_we=1, flush/bubble outputs=0.
- hz = ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority 1, dmem_busy=1: freeze.
  - pc_we=if_id_we=id_ex_we=ex_mem_we=0, mem_wb_bubble=1.
  - state, bcnt and perf counters hold; ex_branch_taken and hz are ignored this cycle and re-evaluated once the pipeline advances.
  - wcnt increments and saturates; when wcnt reaches MEM_TIMEOUT-1 with dmem_busy still 1, mem_timeout sets and stays set until reset.
  - wcnt clears on any cycle with dmem_busy=0.
- Priority 2, ex_branch_taken=1 (not frozen): flush.
  - pc_we=1 (target loads), if_id_flush=1, id_ex_bubble=1.
  - flush_events++.
  - state->RUN and bcnt->0; this aborts any load-use stall in progress.
- Priority 3, RUN with hz=1: stall.
  - pc_we=0, if_id_we=0, id_ex_bubble=1; stall_cycles++.
  - If LOAD_LAT>1: bcnt<=LOAD_LAT-2 and state->STALL; otherwise stay in RUN.
- Priority 3, STALL:
  - The stall is held unconditionally (same outputs and stall_cycles++), independent of hz; ID contents are frozen.
  - If bcnt==0, state->RUN; else bcnt--.
- Total bubbles per hazard: exactly LOAD_LAT, unless a branch flush or reset intervenes. A freeze mid-stall extends the wall-clock time but not the bubble count.
- Perf counters saturate at all-ones and never wrap.
- Reset mid-stall or mid-freeze: immediate return to RUN, no residual bubbles after release.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1, LOAD_LAT=1 -> one cycle pc_we=0, if_id_we=0, id_ex_bubble=1; stall_cycles=1; next cycle defaults.
- Multi-bubble: LOAD_LAT=2, hazard on rt=7, hz dropped after cycle 1 -> two consecutive stall cycles, then RUN; stall_cycles=2. Also ex_rd=0 with matching id_rs=0 -> no stall.
- Branch vs stall: LOAD_LAT=3, hazard cycle 0, ex_branch_taken=1 in cycle 1 -> cycle 1 has pc_we=1, if_id_flush=1, id_ex_bubble=1; cycle 2 defaults; flush_events=1, stall_cycles=1.
- Freeze: dmem_busy=1 for 3 cycles during STALL (LOAD_LAT=2) -> all we=0 and mem_wb_bubble=1 for those 3 cycles, stall_cycles unchanged, remaining bubble issued after dmem_busy drops.
- Watchdog: MEM_TIMEOUT=4, dmem_busy held 4 cycles -> mem_timeout=1 after the 4th edge, stays 1 after dmem_busy=0 until reset.
- Saturation/reset: CNT_W=2, 5 flushes -> flush_events=3; assert reset mid-STALL -> outputs show the reset values immediately, then defaults after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, data-memory freezes, saturating perf counters and a memory watchdog.
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout
);

    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0]        BCNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    typedef enum logic {RUN, STALL} state_t;

    state_t             state_q, state_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   flush_events_q, flush_events_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               hz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign hz = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    always_comb begin
        pc_we          = 1'b1;
        if_id_we       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_we       = 1'b1;
        id_ex_bubble   = 1'b0;
        ex_mem_we      = 1'b1;
        mem_wb_bubble  = 1'b0;
        state_d        = state_q;
        bcnt_d         = bcnt_q;
        wcnt_d         = '0;
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        mem_timeout_d  = mem_timeout_q;

        if (reset) begin
            // Hold every register still and feed NOPs while reset is asserted
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (dmem_busy) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_bubble = 1'b1;
            wcnt_d        = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + WCNT_W'(1);
            if (wcnt_q == WCNT_MAX) begin
                mem_timeout_d = 1'b1;
            end
        end else if (ex_branch_taken) begin
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            flush_events_d = sat_inc(flush_events_q);
            state_d        = RUN;
            bcnt_d         = 2'd0;
        end else if ((state_q == STALL) || hz) begin
            pc_we          = 1'b0;
            if_id_we       = 1'b0;
            id_ex_bubble   = 1'b1;
            stall_cycles_d = sat_inc(stall_cycles_q);
            if (state_q == STALL) begin
                // Remaining bubbles are issued regardless of hz: ID is frozen
                if (bcnt_q == 2'd0) begin
                    state_d = RUN;
                end else begin
                    bcnt_d = bcnt_q - 2'd1;
                end
            end else if (LOAD_LAT > 1) begin
                state_d = STALL;
                bcnt_d  = BCNT_INIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            bcnt_q         <= 2'd0;
            wcnt_q         <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bcnt_q         <= bcnt_d;
            wcnt_q         <= wcnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three parameterisations share one stimulus stream and
// are compared to a remaining-bubble reference model, vector tables and directed sequences.
module tb_pipe_hazard_ctrl;

    // Control bundle: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}
    localparam logic [6:0] DEF  = 7'b1101010;
    localparam logic [6:0] STL  = 7'b0001110;
    localparam logic [6:0] FLS  = 7'b1111110;
    localparam logic [6:0] FRZ  = 7'b0000001;
    localparam logic [6:0] RSTV = 7'b0010101;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken, dmem_busy;

    logic [6:0]  ctl   [3];
    logic [15:0] sc    [3];
    logic [15:0] fe    [3];
    logic        to    [3];
    logic [6:0]  snap  [3];

    logic        o_pc0, o_ifwe0, o_iff0, o_idwe0, o_idb0, o_exwe0, o_mwb0, o_to0;
    logic        o_pc1, o_ifwe1, o_iff1, o_idwe1, o_idb1, o_exwe1, o_mwb1, o_to1;
    logic        o_pc2, o_ifwe2, o_iff2, o_idwe2, o_idb2, o_exwe2, o_mwb2, o_to2;
    logic [1:0]  o_sc0, o_fe0;
    logic [15:0] o_sc1, o_fe1, o_sc2, o_fe2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int LL [3] = '{1, 2, 3};
    int MT [3] = '{4, 64, 64};
    int CW [3] = '{2, 16, 16};
    int m_rem   [3];
    int m_stall [3];
    int m_flush [3];
    int m_wrun  [3];
    int m_to    [3];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(4), .CNT_W(2)) u0 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pc_we(o_pc0), .if_id_we(o_ifwe0), .if_id_flush(o_iff0), .id_ex_we(o_idwe0),
        .id_ex_bubble(o_idb0), .ex_mem_we(o_exwe0), .mem_wb_bubble(o_mwb0),
        .stall_cycles(o_sc0), .flush_events(o_fe0), .mem_timeout(o_to0));

    pipe_hazard_ctrl #(.LOAD_LAT(2), .MEM_TIMEOUT(64), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pc_we(o_pc1), .if_id_we(o_ifwe1), .if_id_flush(o_iff1), .id_ex_we(o_idwe1),
        .id_ex_bubble(o_idb1), .ex_mem_we(o_exwe1), .mem_wb_bubble(o_mwb1),
        .stall_cycles(o_sc1), .flush_events(o_fe1), .mem_timeout(o_to1));

    pipe_hazard_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(64), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pc_we(o_pc2), .if_id_we(o_ifwe2), .if_id_flush(o_iff2), .id_ex_we(o_idwe2),
        .id_ex_bubble(o_idb2), .ex_mem_we(o_exwe2), .mem_wb_bubble(o_mwb2),
        .stall_cycles(o_sc2), .flush_events(o_fe2), .mem_timeout(o_to2));

    assign ctl[0] = {o_pc0, o_ifwe0, o_iff0, o_idwe0, o_idb0, o_exwe0, o_mwb0};
    assign ctl[1] = {o_pc1, o_ifwe1, o_iff1, o_idwe1, o_idb1, o_exwe1, o_mwb1};
    assign ctl[2] = {o_pc2, o_ifwe2, o_iff2, o_idwe2, o_idb2, o_exwe2, o_mwb2};
    assign sc[0]  = {14'd0, o_sc0};
    assign fe[0]  = {14'd0, o_fe0};
    assign sc[1]  = o_sc1;
    assign fe[1]  = o_fe1;
    assign sc[2]  = o_sc2;
    assign fe[2]  = o_fe2;
    assign to[0]  = o_to0;
    assign to[1]  = o_to1;
    assign to[2]  = o_to2;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_hz();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    endfunction

    function automatic logic [6:0] m_ctl(input int k);
        if (reset) return RSTV;
        if (dmem_busy) return FRZ;
        if (ex_branch_taken) return FLS;
        if (m_rem[k] > 0 || m_hz()) return STL;
        return DEF;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 3; k++) begin
            m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_wrun[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic m_edge();
        bit h;
        h = m_hz();
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_wrun[k] = 0; m_to[k] = 0;
            end else if (dmem_busy) begin
                if (m_wrun[k] < 1000) m_wrun[k]++;
                if (m_wrun[k] >= MT[k]) m_to[k] = 1;
            end else begin
                m_wrun[k] = 0;
                if (ex_branch_taken) begin
                    if (m_flush[k] < (1 << CW[k]) - 1) m_flush[k]++;
                    m_rem[k] = 0;
                end else if (m_rem[k] > 0 || h) begin
                    if (m_stall[k] < (1 << CW[k]) - 1) m_stall[k]++;
                    m_rem[k] = (m_rem[k] > 0) ? m_rem[k] - 1 : LL[k] - 1;
                end
            end
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic mr, input logic [4:0] rd,
                          input logic br, input logic busy);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; dmem_busy = busy;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic step();
        if (reset) m_clear();
        #1;
        for (int k = 0; k < 3; k++) begin
            snap[k] = ctl[k];
            chk($sformatf("model_ctl_d%0d", k), {9'd0, ctl[k]}, {9'd0, m_ctl(k)});
        end
        @(posedge clk);
        m_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_stall_d%0d", k), sc[k], 16'(m_stall[k]));
            chk($sformatf("model_flush_d%0d", k), fe[k], 16'(m_flush[k]));
            chk($sformatf("model_timeout_d%0d", k), {15'd0, to[k]}, 16'(m_to[k]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        m_clear();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ctl_d%0d", k), {9'd0, ctl[k]}, {9'd0, RSTV});
            chk($sformatf("rst_stall_d%0d", k), sc[k], 16'd0);
            chk($sformatf("rst_flush_d%0d", k), fe[k], 16'd0);
            chk($sformatf("rst_timeout_d%0d", k), {15'd0, to[k]}, 16'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt, mr;
        logic [4:0] rd;
        logic       br, busy;
        logic [6:0] exp;
    } vec_t;

    vec_t vt [10];

    initial begin
        vt[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, DEF};
        vt[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, STL};
        vt[2] = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, DEF};
        vt[3] = '{5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, STL};
        vt[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, DEF};
        vt[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, DEF};
        vt[6] = '{5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, STL};
        vt[7] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, FLS};
        vt[8] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, FRZ};
        vt[9] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, FRZ};

        reset = 1'b1;
        idle();
        m_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Decode table on the single-bubble instance
        for (int i = 0; i < 10; i++) begin
            set_in(vt[i].rs, vt[i].rt, vt[i].urs, vt[i].urt, vt[i].mr, vt[i].rd, vt[i].br, vt[i].busy);
            step();
            chk($sformatf("table_%0d", i), {9'd0, snap[0]}, {9'd0, vt[i].exp});
        end

        // Load-use on rt=7 held for one cycle: 1/2/3 bubbles per instance
        do_reset();
        set_in(5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        step();
        chk("lu_c0_d0", {9'd0, snap[0]}, {9'd0, STL});
        chk("lu_c0_d1", {9'd0, snap[1]}, {9'd0, STL});
        chk("lu_c0_stall_d0", sc[0], 16'd1);
        idle();
        step();
        chk("lu_c1_d0", {9'd0, snap[0]}, {9'd0, DEF});
        chk("lu_c1_d1", {9'd0, snap[1]}, {9'd0, STL});
        chk("lu_c1_d2", {9'd0, snap[2]}, {9'd0, STL});
        step();
        chk("lu_c2_d1", {9'd0, snap[1]}, {9'd0, DEF});
        chk("lu_c2_d2", {9'd0, snap[2]}, {9'd0, STL});
        step();
        chk("lu_c3_d2", {9'd0, snap[2]}, {9'd0, DEF});
        chk("lu_stall_d1", sc[1], 16'd2);
        chk("lu_stall_d2", sc[2], 16'd3);

        // Branch aborts a multi-cycle stall
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        chk("br_c1_d2", {9'd0, snap[2]}, {9'd0, FLS});
        idle();
        step();
        chk("br_c2_d2", {9'd0, snap[2]}, {9'd0, DEF});
        chk("br_flush_d2", fe[2], 16'd1);
        chk("br_stall_d2", sc[2], 16'd1);

        // Freeze in the middle of a stall
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
            step();
            chk($sformatf("frz_c%0d_d1", i + 1), {9'd0, snap[1]}, {9'd0, FRZ});
        end
        chk("frz_stall_hold_d1", sc[1], 16'd1);
        idle();
        step();
        chk("frz_c4_d1", {9'd0, snap[1]}, {9'd0, STL});
        chk("frz_c4_d0", {9'd0, snap[0]}, {9'd0, DEF});
        step();
        chk("frz_c5_d1", {9'd0, snap[1]}, {9'd0, DEF});
        chk("frz_stall_d1", sc[1], 16'd2);
        chk("frz_timeout_d0", {15'd0, to[0]}, 16'd0);

        // Watchdog on the MEM_TIMEOUT=4 instance
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("wd_e%0d_d0", i + 1), {15'd0, to[0]}, (i == 3) ? 16'd1 : 16'd0);
        end
        chk("wd_d1", {15'd0, to[1]}, 16'd0);
        idle();
        step();
        step();
        chk("wd_sticky_d0", {15'd0, to[0]}, 16'd1);

        // Counter saturation, then reset in the middle of a stall
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("sat_flush_d0", fe[0], 16'd3);
        chk("sat_flush_d1", fe[1], 16'd5);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step();
        #3;
        do_reset();
        idle();
        step();
        chk("post_rst_c0_d2", {9'd0, snap[2]}, {9'd0, DEF});
        step();
        chk("post_rst_c1_d2", {9'd0, snap[2]}, {9'd0, DEF});
        chk("post_rst_stall_d2", sc[2], 16'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset           = ($urandom_range(0, 59) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) != 0);
            ex_rd           = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            dmem_busy       = ($urandom_range(0, 4) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
